// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode ECALL / MRET sequencer.
//
// An accepted ECALL takes two cycles to produce a fetch redirect: the first
// cycle writes the captured PC into mepc, the second samples mtvec and starts
// the redirect. An accepted MRET redirects to mepc after one cycle. The
// redirect is held until fetch accepts it, then the block returns to IDLE.
//
// Optional feature: define TRAP_MCAUSE_EN to add an mcause register that is
// loaded with 11 (M-mode ECALL) on every ECALL. Without it mcause_o is 0.
module trap_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ecall_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            mepc_wen_o,
    output logic [XLEN-1:0] mepc_wdata_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    input  logic            redirect_ready_i,
    output logic            busy_o,
    output logic [XLEN-1:0] mcause_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SAVE     = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    state_e          state_q;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] target_q;
    logic            req_ready_q;
    logic            busy_q;
    logic            mepc_wen_q;
    logic            redirect_valid_q;

    // Trap sequencing FSM; every handshake output is a register so fetch and
    // the CSR file see clean, glitch-free strobes.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register here samples the values present before this edge.
        if (!rst_ni) begin
            state_q          <= ST_IDLE;
            epc_q            <= '0;
            target_q         <= '0;
            req_ready_q      <= 1'b1;
            busy_q           <= 1'b0;
            mepc_wen_q       <= 1'b0;
            redirect_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // ECALL has priority; a simultaneous MRET is dropped.
                    if (ecall_i) begin
                        epc_q       <= pc_i;
                        state_q     <= ST_SAVE;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        mepc_wen_q  <= 1'b1;
                    end else if (mret_i) begin
                        target_q         <= mepc_i;
                        state_q          <= ST_REDIRECT;
                        req_ready_q      <= 1'b0;
                        busy_q           <= 1'b1;
                        redirect_valid_q <= 1'b1;
                    end
                end
                ST_SAVE: begin
                    // mtvec is sampled here rather than at acceptance so a CSR
                    // write retiring just ahead of the ECALL is honoured.
                    target_q         <= mtvec_i;
                    state_q          <= ST_REDIRECT;
                    mepc_wen_q       <= 1'b0;
                    redirect_valid_q <= 1'b1;
                end
                ST_REDIRECT: begin
                    if (redirect_ready_i) begin
                        state_q          <= ST_IDLE;
                        req_ready_q      <= 1'b1;
                        busy_q           <= 1'b0;
                        redirect_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q          <= ST_IDLE;
                    req_ready_q      <= 1'b1;
                    busy_q           <= 1'b0;
                    mepc_wen_q       <= 1'b0;
                    redirect_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o      = req_ready_q;
    assign busy_o           = busy_q;
    assign mepc_wen_o       = mepc_wen_q;
    assign mepc_wdata_o     = mepc_wen_q ? epc_q : '0;
    assign redirect_valid_o = redirect_valid_q;
    // Direct mode only: the target is always forced to word alignment.
    assign redirect_pc_o    = target_q & ~XLEN'(3);

`ifdef TRAP_MCAUSE_EN
    logic [XLEN-1:0] mcause_q;

    // Cause register: set to M-mode ECALL on every ECALL, untouched by MRET.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mcause_q <= '0;
        end else if (state_q == ST_SAVE) begin
            mcause_q <= XLEN'(11);
        end
    end

    assign mcause_o = mcause_q;
`else
    assign mcause_o = '0;
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed and randomized checks of trap_ctrl against an
// output-level reference model. Honours TRAP_MCAUSE_EN for mcause_o.
module tb_trap_ctrl;

    localparam int XLEN = 32;
`ifdef TRAP_MCAUSE_EN
    localparam logic [XLEN-1:0] CAUSE_ECALL = 32'd11;
`else
    localparam logic [XLEN-1:0] CAUSE_ECALL = 32'd0;
`endif
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            ecall_i;
    logic            mret_i;
    logic [XLEN-1:0] pc_i;
    logic            req_ready_o;
    logic [XLEN-1:0] mtvec_i;
    logic [XLEN-1:0] mepc_i;
    logic            mepc_wen_o;
    logic [XLEN-1:0] mepc_wdata_o;
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            redirect_ready_i;
    logic            busy_o;
    logic [XLEN-1:0] mcause_o;

    int compared   = 0;
    int mismatched = 0;

    // Reference model of the observable outputs after each edge.
    logic            m_wen;
    logic [XLEN-1:0] m_wdata;
    logic            m_valid;
    logic [XLEN-1:0] m_pc;
    logic [XLEN-1:0] m_cause;

    trap_ctrl #(.XLEN(XLEN)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .ecall_i          (ecall_i),
        .mret_i           (mret_i),
        .pc_i             (pc_i),
        .req_ready_o      (req_ready_o),
        .mtvec_i          (mtvec_i),
        .mepc_i           (mepc_i),
        .mepc_wen_o       (mepc_wen_o),
        .mepc_wdata_o     (mepc_wdata_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_ready_i (redirect_ready_i),
        .busy_o           (busy_o),
        .mcause_o         (mcause_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Apply the current inputs across one rising edge, advance the model from
    // those same inputs, then compare every output 1 time unit after the edge.
    task automatic tick();
        logic            r, e, m, rd;
        logic [XLEN-1:0] p, tv, mp;
        r = rst_ni; e = ecall_i; m = mret_i; rd = redirect_ready_i;
        p = pc_i; tv = mtvec_i; mp = mepc_i;
        @(posedge clk);
        #1;
        if (!r) begin
            m_wen = 1'b0; m_wdata = '0; m_valid = 1'b0; m_pc = '0; m_cause = '0;
        end else if (m_wen) begin
            // The mepc write cycle is followed by the redirect to mtvec.
            m_wen = 1'b0; m_wdata = '0;
            m_valid = 1'b1; m_pc = tv & ALIGN_MASK; m_cause = CAUSE_ECALL;
        end else if (m_valid) begin
            if (rd) m_valid = 1'b0;
        end else if (e) begin
            m_wen = 1'b1; m_wdata = p;
        end else if (m) begin
            m_valid = 1'b1; m_pc = mp & ALIGN_MASK;
        end
        check("m_ready",  XLEN'(req_ready_o),      XLEN'(!m_wen && !m_valid));
        check("m_busy",   XLEN'(busy_o),           XLEN'(m_wen || m_valid));
        check("m_wen",    XLEN'(mepc_wen_o),       XLEN'(m_wen));
        check("m_wdata",  mepc_wdata_o,            m_wdata);
        check("m_valid",  XLEN'(redirect_valid_o), XLEN'(m_valid));
        check("m_rpc",    redirect_pc_o,           m_pc);
        check("m_cause",  mcause_o,                m_cause);
    endtask

    initial begin
        m_wen = 1'b0; m_wdata = '0; m_valid = 1'b0; m_pc = '0; m_cause = '0;
        rst_ni = 1'b0; ecall_i = 1'b0; mret_i = 1'b0; redirect_ready_i = 1'b0;
        pc_i = '0; mtvec_i = '0; mepc_i = '0;

        // Reset values.
        tick();
        tick();
        check("rst_ready", XLEN'(req_ready_o), 32'd1);
        check("rst_busy",  XLEN'(busy_o), 32'd0);
        check("rst_wen",   XLEN'(mepc_wen_o), 32'd0);
        check("rst_wdata", mepc_wdata_o, 32'd0);
        check("rst_valid", XLEN'(redirect_valid_o), 32'd0);
        check("rst_rpc",   redirect_pc_o, 32'd0);
        check("rst_cause", mcause_o, 32'd0);
        rst_ni = 1'b1;
        tick();

        // ECALL: mepc write at +1, redirect to mtvec at +2.
        ecall_i = 1'b1; pc_i = 32'h8000_0010; mtvec_i = 32'h8000_0100;
        tick();
        ecall_i = 1'b0;
        check("ecall_wen",   XLEN'(mepc_wen_o), 32'd1);
        check("ecall_wdata", mepc_wdata_o, 32'h8000_0010);
        check("ecall_busy",  XLEN'(busy_o), 32'd1);
        tick();
        check("ecall_valid", XLEN'(redirect_valid_o), 32'd1);
        check("ecall_rpc",   redirect_pc_o, 32'h8000_0100);
        check("ecall_cause", mcause_o, CAUSE_ECALL);

        // Redirect held for 5 cycles; requests and new mtvec are ignored.
        ecall_i = 1'b1; mret_i = 1'b1; mtvec_i = 32'h1234_5678; mepc_i = 32'h0BAD_0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", XLEN'(redirect_valid_o), 32'd1);
            check("hold_rpc",   redirect_pc_o, 32'h8000_0100);
            check("hold_busy",  XLEN'(busy_o), 32'd1);
            check("hold_wen",   XLEN'(mepc_wen_o), 32'd0);
        end
        ecall_i = 1'b0; mret_i = 1'b0; redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0;
        check("ret_ready", XLEN'(req_ready_o), 32'd1);
        check("ret_valid", XLEN'(redirect_valid_o), 32'd0);

        // MRET: redirect to mepc after one cycle, no mepc write.
        mret_i = 1'b1; mepc_i = 32'h8000_0014;
        tick();
        mret_i = 1'b0; redirect_ready_i = 1'b1;
        check("mret_valid", XLEN'(redirect_valid_o), 32'd1);
        check("mret_rpc",   redirect_pc_o, 32'h8000_0014);
        check("mret_wen",   XLEN'(mepc_wen_o), 32'd0);
        check("mret_cause", mcause_o, CAUSE_ECALL);
        tick();
        redirect_ready_i = 1'b0;
        check("mret_wen2",  XLEN'(mepc_wen_o), 32'd0);
        check("mret_idle",  XLEN'(req_ready_o), 32'd1);
        check("mret_cause2", mcause_o, CAUSE_ECALL);

        // ECALL and MRET together: ECALL wins, target is word aligned.
        ecall_i = 1'b1; mret_i = 1'b1; pc_i = 32'h8000_0020;
        mtvec_i = 32'h8000_0103; mepc_i = 32'h9000_0000;
        tick();
        ecall_i = 1'b0; mret_i = 1'b0;
        check("both_wen",   XLEN'(mepc_wen_o), 32'd1);
        check("both_wdata", mepc_wdata_o, 32'h8000_0020);
        tick();
        check("both_rpc",   redirect_pc_o, 32'h8000_0100);
        redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0;

        // Reset during SAVE suppresses the write and restores reset outputs.
        ecall_i = 1'b1; pc_i = 32'h8000_0040; mtvec_i = 32'h8000_0200;
        tick();
        ecall_i = 1'b0;
        check("rsave_wen_pre", XLEN'(mepc_wen_o), 32'd1);
        rst_ni = 1'b0;
        tick();
        check("rsave_wen",   XLEN'(mepc_wen_o), 32'd0);
        check("rsave_wdata", mepc_wdata_o, 32'd0);
        check("rsave_ready", XLEN'(req_ready_o), 32'd1);
        check("rsave_busy",  XLEN'(busy_o), 32'd0);
        check("rsave_valid", XLEN'(redirect_valid_o), 32'd0);
        check("rsave_rpc",   redirect_pc_o, 32'd0);
        check("rsave_cause", mcause_o, 32'd0);
        rst_ni = 1'b1;
        tick();
        check("rsave_wen_post", XLEN'(mepc_wen_o), 32'd0);
        check("rsave_valid_post", XLEN'(redirect_valid_o), 32'd0);

        // Randomized traffic including occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst_ni           = ($urandom_range(0, 49) != 0);
            ecall_i          = ($urandom_range(0, 3) == 0);
            mret_i           = ($urandom_range(0, 3) == 0);
            redirect_ready_i = ($urandom_range(0, 1) == 0);
            pc_i             = $urandom;
            mtvec_i          = $urandom;
            mepc_i           = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
